// File: rtl/rf_wb_arbiter_if.sv
// Bundle of pipeline WB, mul/div result and register-file write signals
// shared between the write-back arbiter and its surroundings.
interface rf_wb_arbiter_if;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        md_valid;
    logic [4:0]  md_rd;
    logic [31:0] md_data;
    logic        md_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] busy_mask;
    logic        stall_req;

    modport master (
        output wb_we, wb_rd, wb_data, md_valid, md_rd, md_data,
        input  md_ready, rf_we, rf_waddr, rf_wdata, busy_mask, stall_req
    );

    modport slave (
        input  wb_we, wb_rd, wb_data, md_valid, md_rd, md_data,
        output md_ready, rf_we, rf_waddr, rf_wdata, busy_mask, stall_req
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Single-port register-file write arbiter: pipeline WB always wins, mul/div
// results wait in a FIFO, are killed on WAW, and raise stall_req when starved.
module rf_wb_arbiter #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic           clk,
    input  logic           reset,
    rf_wb_arbiter_if.slave bus
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]       rd_q   [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [DEPTH-1:0] live_q, live_d;
    logic [PW-1:0]    head_q, tail_q;
    logic [CW-1:0]    count_q;
    logic [SW-1:0]    starve_q;
    logic             rf_we_q;
    logic [4:0]       rf_waddr_q;
    logic [31:0]      rf_wdata_q;

    logic        wb_valid, ready, push, pop, head_live;
    logic [31:0] busy;

    always_comb begin
        wb_valid  = bus.wb_we && (bus.wb_rd != '0);
        ready     = count_q < CW'(DEPTH);
        push      = bus.md_valid && ready && (bus.md_rd != '0);
        pop       = !wb_valid && (count_q != '0);
        head_live = live_q[head_q];

        // Freed slots always have live cleared, so the kill can scan every slot.
        live_d = live_q;
        if (wb_valid) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (rd_q[i] == bus.wb_rd) live_d[i] = 1'b0;
            end
        end
        if (pop)  live_d[head_q] = 1'b0;
        if (push) live_d[tail_q] = 1'b1;

        busy = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (live_q[i]) busy[rd_q[i]] = 1'b1;
        end
        busy[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            rd_q[tail_q]   <= bus.md_rd;
            data_q[tail_q] <= bus.md_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            live_q     <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            starve_q   <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            live_q <= live_d;
            if (push) tail_q <= tail_q + PW'(1);
            if (pop)  head_q <= head_q + PW'(1);
            if (push && !pop)      count_q <= count_q + CW'(1);
            else if (!push && pop) count_q <= count_q - CW'(1);

            if ((count_q == '0) || pop)
                starve_q <= '0;
            else if (wb_valid && (starve_q != SW'(STARVE_LIMIT)))
                starve_q <= starve_q + SW'(1);

            rf_we_q <= wb_valid || (pop && head_live);
            if (wb_valid) begin
                rf_waddr_q <= bus.wb_rd;
                rf_wdata_q <= bus.wb_data;
            end else if (pop && head_live) begin
                rf_waddr_q <= rd_q[head_q];
                rf_wdata_q <= data_q[head_q];
            end
        end
    end

    assign bus.md_ready  = ready;
    assign bus.rf_we     = rf_we_q;
    assign bus.rf_waddr  = rf_waddr_q;
    assign bus.rf_wdata  = rf_wdata_q;
    assign bus.busy_mask = busy;
    assign bus.stall_req = (starve_q == SW'(STARVE_LIMIT));
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Table-driven bench for rf_wb_arbiter with a scoreboard of expected
// register-file writes; reset cases are driven by hand.
module tb_rf_wb_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int failures = 0;

    rf_wb_arbiter_if bus ();

    rf_wb_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wb_we;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        logic        md_valid;
        logic [4:0]  md_rd;
        logic [31:0] md_data;
        logic        e_we;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic [31:0] e_busy;
        logic        e_rdy;
        logic        e_stall;
    } vec_t;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    vec_t vecs[$];
    wr_t  sb[$];

    function automatic void add(input logic wwe, input logic [4:0] wrd, input logic [31:0] wd,
                                input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                                input logic ewe, input logic [4:0] ea, input logic [31:0] ed,
                                input logic [31:0] eb, input logic er, input logic es);
        vec_t v;
        v.wb_we = wwe; v.wb_rd = wrd; v.wb_data = wd;
        v.md_valid = mv; v.md_rd = mrd; v.md_data = md;
        v.e_we = ewe; v.e_addr = ea; v.e_data = ed;
        v.e_busy = eb; v.e_rdy = er; v.e_stall = es;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic sb_check(input string tag);
        wr_t w;
        if (bus.rf_we === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL %s_sb unexpected write addr=%0d data=%h", tag, bus.rf_waddr, bus.rf_wdata);
            end else begin
                w = sb.pop_front();
                check({tag, "_sb_addr"}, {27'd0, bus.rf_waddr}, {27'd0, w.a});
                check({tag, "_sb_data"}, bus.rf_wdata, w.d);
            end
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        wr_t w;
        string tag;
        tag = $sformatf("v%0d", idx);
        @(negedge clk);
        bus.wb_we = v.wb_we; bus.wb_rd = v.wb_rd; bus.wb_data = v.wb_data;
        bus.md_valid = v.md_valid; bus.md_rd = v.md_rd; bus.md_data = v.md_data;
        if (v.e_we) begin
            w.a = v.e_addr;
            w.d = v.e_data;
            sb.push_back(w);
        end
        @(posedge clk);
        #1;
        check({tag, "_we"},    {31'd0, bus.rf_we},     {31'd0, v.e_we});
        check({tag, "_addr"},  {27'd0, bus.rf_waddr},  {27'd0, v.e_addr});
        check({tag, "_data"},  bus.rf_wdata,           v.e_data);
        check({tag, "_busy"},  bus.busy_mask,          v.e_busy);
        check({tag, "_ready"}, {31'd0, bus.md_ready},  {31'd0, v.e_rdy});
        check({tag, "_stall"}, {31'd0, bus.stall_req}, {31'd0, v.e_stall});
        sb_check(tag);
    endtask

    initial begin
        bus.wb_we = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;
        bus.md_valid = 1'b0; bus.md_rd = '0; bus.md_data = '0;

        // wb_we wb_rd wb_data | md_valid md_rd md_data | we addr data busy ready stall
        add(1, 5, 32'h1234, 0, 0, 0,         1, 5, 32'h1234, 32'h0, 1, 0);
        add(0, 0, 0,        0, 0, 0,         0, 5, 32'h1234, 32'h0, 1, 0);
        add(0, 0, 0,        1, 8, 32'hCAFE,  0, 5, 32'h1234, 32'h100, 1, 0);
        add(0, 0, 0,        0, 0, 0,         1, 8, 32'hCAFE, 32'h0, 1, 0);
        add(1, 0, 32'hDEAD, 0, 0, 0,         0, 8, 32'hCAFE, 32'h0, 1, 0);
        add(0, 0, 0,        1, 0, 32'h5555,  0, 8, 32'hCAFE, 32'h0, 1, 0);
        add(0, 0, 0,        0, 0, 0,         0, 8, 32'hCAFE, 32'h0, 1, 0);
        // fill with WB busy every cycle
        add(1, 1, 32'h11,   1, 10, 32'hA0,   1, 1, 32'h11, 32'h400,  1, 0);
        add(1, 2, 32'h22,   1, 11, 32'hA1,   1, 2, 32'h22, 32'hC00,  1, 0);
        add(1, 3, 32'h33,   1, 12, 32'hA2,   1, 3, 32'h33, 32'h1C00, 1, 0);
        add(1, 4, 32'h44,   1, 13, 32'hA3,   1, 4, 32'h44, 32'h3C00, 0, 0);
        add(1, 5, 32'h55,   1, 14, 32'hA4,   1, 5, 32'h55, 32'h3C00, 0, 0);
        add(0, 0, 0,        1, 14, 32'hA4,   1, 10, 32'hA0, 32'h3800, 1, 0);
        add(0, 0, 0,        1, 14, 32'hA4,   1, 11, 32'hA1, 32'h7000, 1, 0);
        add(0, 0, 0,        0, 0, 0,         1, 12, 32'hA2, 32'h6000, 1, 0);
        add(0, 0, 0,        0, 0, 0,         1, 13, 32'hA3, 32'h4000, 1, 0);
        add(0, 0, 0,        0, 0, 0,         1, 14, 32'hA4, 32'h0,    1, 0);
        add(0, 0, 0,        0, 0, 0,         0, 14, 32'hA4, 32'h0,    1, 0);
        // WAW kill, then same-cycle enqueue to the WB register stays live
        add(0, 0, 0,        1, 3, 32'hAAAA,  0, 14, 32'hA4, 32'h8,    1, 0);
        add(1, 3, 32'hBBBB, 0, 0, 0,         1, 3, 32'hBBBB, 32'h0,   1, 0);
        add(0, 0, 0,        0, 0, 0,         0, 3, 32'hBBBB, 32'h0,   1, 0);
        add(1, 7, 32'h77,   1, 7, 32'h7A,    1, 7, 32'h77, 32'h80,    1, 0);
        add(0, 0, 0,        0, 0, 0,         1, 7, 32'h7A, 32'h0,     1, 0);
        // starvation
        add(0, 0, 0,        1, 9, 32'h99,    0, 7, 32'h7A, 32'h200,   1, 0);
        for (int k = 0; k < 8; k++)
            add(1, 20, 32'h100 + 32'(k), 0, 0, 0, 1, 20, 32'h100 + 32'(k), 32'h200, 1, (k == 7));
        add(1, 20, 32'h108, 0, 0, 0,         1, 20, 32'h108, 32'h200, 1, 1);
        add(0, 0, 0,        0, 0, 0,         1, 9, 32'h99, 32'h0,     1, 0);

        repeat (2) @(posedge clk);
        #1;
        check("rst_we",    {31'd0, bus.rf_we},     32'd0);
        check("rst_addr",  {27'd0, bus.rf_waddr},  32'd0);
        check("rst_data",  bus.rf_wdata,           32'd0);
        check("rst_busy",  bus.busy_mask,          32'd0);
        check("rst_ready", {31'd0, bus.md_ready},  32'd1);
        check("rst_stall", {31'd0, bus.stall_req}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        // three entries queued behind a busy WB, then asynchronous reset mid-cycle
        begin
            vec_t v;
            for (int k = 0; k < 3; k++) begin
                v.wb_we = 1; v.wb_rd = 5'(21 + k); v.wb_data = 32'h2100 + 32'(k);
                v.md_valid = 1; v.md_rd = 5'(24 + k); v.md_data = 32'h2400 + 32'(k);
                v.e_we = 1; v.e_addr = 5'(21 + k); v.e_data = 32'h2100 + 32'(k);
                v.e_busy = (k == 0) ? 32'h0100_0000 : (k == 1) ? 32'h0300_0000 : 32'h0700_0000;
                v.e_rdy = 1; v.e_stall = 0;
                apply(v, 100 + k);
            end
        end
        @(negedge clk);
        bus.wb_we = 1'b0; bus.md_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("arst_busy",  bus.busy_mask,          32'd0);
        check("arst_ready", {31'd0, bus.md_ready},  32'd1);
        check("arst_we",    {31'd0, bus.rf_we},     32'd0);
        check("arst_stall", {31'd0, bus.stall_req}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("post_rst%0d_we", k),   {31'd0, bus.rf_we}, 32'd0);
            check($sformatf("post_rst%0d_busy", k), bus.busy_mask,      32'd0);
        end
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameter DEPTH, default 4, capacity of the mul/div result queue (power of two, 2..16).
REQ-002 Parameter STARVE_LIMIT, default 8, consecutive lost-arbitration cycles before stall_req.
REQ-003 reset  input  1  asynchronous, active-high.
REQ-004 clk  input  1  clock, all state updates on rising edge.
REQ-005 wb_we  input  1  pipeline WB stage write request; highest priority, no backpressure.
REQ-006 wb_rd  input  5  pipeline destination register.
REQ-007 wb_data  input  32  pipeline write data.
REQ-008 md_valid  input  1  multi-cycle mul/div unit offers a result.
REQ-009 md_rd  input  5  mul/div destination register.
REQ-010 md_data  input  32  mul/div result data.
REQ-011 md_ready  output  1  queue can accept a result this cycle.
REQ-012 rf_we  output  1  register-file write enable (registered).
REQ-013 rf_waddr  output  5  register-file write address (registered).
REQ-014 rf_wdata  output  32  register-file write data (registered).
REQ-015 busy_mask  output  32  bit n set = a live queued mul/div write to register n exists; bit 0 always 0.
REQ-016 stall_req  output  1  request to pipeline to bubble WB so the queue drains.

Function
REQ-017 Single write port; per cycle exactly one winner or none; result appears on rf_* one cycle after the arbitration cycle.
REQ-018 WB valid = wb_we and wb_rd != 0; WB valid always wins, drives rf_we=1, rf_waddr=wb_rd, rf_wdata=wb_data next cycle.
REQ-019 wb_we with wb_rd == 0 is not a request; it does not occupy the port.
REQ-020 If WB not valid and queue holds a live head entry, head is popped and written next cycle.
REQ-021 Dead (killed) head entries are popped without a write (rf_we=0 next cycle); one pop per cycle max.
REQ-022 If neither source writes, rf_we=0 next cycle; rf_waddr/rf_wdata hold previous values.
REQ-023 md_ready = (occupancy < DEPTH), from registered occupancy only; no same-cycle pop-through.
REQ-024 Handshake: result accepted when md_valid and md_ready; entries are strictly FIFO ordered.
REQ-025 Accepted result with md_rd == 0 is discarded: not enqueued, never written.
REQ-026 Accepted entry enqueued in cycle N is eligible for pop no earlier than cycle N+1 (min md-to-rf_we latency 2 cycles).
REQ-027 WAW kill: when WB valid, every live queued entry with rd == wb_rd (present before this edge) is marked dead; a same-cycle incoming entry with md_rd == wb_rd is enqueued live.
REQ-028 busy_mask is OR of one-hot(rd) over live queued entries, updated each edge for enqueue, pop and kill.
REQ-029 Simultaneous enqueue and pop in one cycle: occupancy unchanged; pointers wrap modulo DEPTH.
REQ-030 Starve counter: increments (saturating at STARVE_LIMIT) each cycle queue is non-empty and WB wins; clears on any pop or when queue empty.
REQ-031 stall_req = (starve counter == STARVE_LIMIT); deasserts the cycle after the next pop.
REQ-032 stall_req is advisory; WB valid still wins while stall_req is high.

Reset
REQ-033 On reset: rf_we=0, rf_waddr=0, rf_wdata=0, busy_mask=0, stall_req=0, md_ready=1, queue empty, pointers and starve counter 0.
REQ-034 Reset mid-operation discards all queued entries with no further writes; effect is immediate, not clock-gated.

Verification
REQ-035 WB only: wb_we=1, wb_rd=5, wb_data=0x1234 at cycle N -> rf_we=1, rf_waddr=5, rf_wdata=0x1234 at N+1; busy_mask=0.
REQ-036 MD idle port: md_valid=1, md_rd=8, md_data=0xCAFE at N, WB idle -> busy_mask[8]=1 at N+1, rf_we=1/waddr 8/wdata 0xCAFE at N+2, busy_mask=0 at N+2.
REQ-037 Fill: DEPTH=4, WB busy every cycle, five md results offered -> md_ready=0 after fourth accept, fifth held until a pop; FIFO order preserved on drain.
REQ-038 WAW kill: queue rd=3 (0xAAAA), then WB writes rd=3 (0xBBBB) -> busy_mask[3] clears, rf writes 0xBBBB only, dead entry popped with rf_we=0.
REQ-039 Starvation: one queued entry, WB valid 8 consecutive cycles -> stall_req=1 after 8th; WB idles -> entry written, stall_req=0 next cycle.
REQ-040 r0/reset: md_rd=0 accepted -> no enqueue, no write; reset asserted with 3 queued -> busy_mask=0, md_ready=1, no rf_we after release.
